// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM driving the datapath control bus.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per mem_ready wait cycle.
// Backpressure: holds mem_req/adr_src/mem_write until mem_ready; optional bus timeout traps.
module riscv_mc_controller #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero_flag,
    input  logic                 mem_ready,
    output logic                 adr_src,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a_sel,
    output logic [1:0]           alu_src_b_sel,
    output logic [2:0]           imm_sel,
    output logic [3:0]           alu_ctrl,
    output logic [2:0]           out_mux_sel,
    output logic                 output_en,
    output logic                 halted,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] retired_count
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_EXEC_I,
        S_ALUWB, S_JALR, S_JAL, S_BRANCH, S_LUI, S_AUIPC, S_HALT, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_SYS = 7'b1110011;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd3, ALU_SLTU = 4'd4;

    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t         state, next_state;
    logic [WW-1:0]  wait_cnt;
    logic           illegal_q, bus_err_q;
    logic           set_illegal, set_bus_err, retire, timed_out, in_wait;
    logic           adr_src_c, mem_req_c, mem_write_c, pc_write_c, ir_write_c, reg_write_c;
    logic [1:0]     a_sel_c, b_sel_c;
    logic [2:0]     imm_sel_c, out_sel_c;
    logic [3:0]     alu_c;
    logic           oe_c, halted_c;
    logic           unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // funct7[5] only alters ADD (R-type only) and SRL.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  op = 4'd2;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = 4'd5;
            3'b101:  op = alt ? 4'd7 : 4'd6;
            3'b110:  op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign in_wait   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        retire      = 1'b0;
        adr_src_c   = 1'b0;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        a_sel_c     = 2'd0;
        b_sel_c     = 2'd0;
        imm_sel_c   = IMM_I;
        out_sel_c   = 3'd0;
        alu_c       = ALU_ADD;
        oe_c        = 1'b0;
        halted_c    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    b_sel_c    = 2'd2;
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_DECODE: begin
                a_sel_c   = 2'd1;
                b_sel_c   = 2'd1;
                imm_sel_c = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_BR:             next_state = S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    OP_SYS:            next_state = S_HALT;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                a_sel_c    = 2'd2;
                b_sel_c    = 2'd1;
                imm_sel_c  = (opcode == OP_STORE) ? IMM_S : IMM_I;
                next_state = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adr_src_c = 1'b1;
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                out_sel_c   = 3'd2;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWR: begin
                adr_src_c   = 1'b1;
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (timed_out) begin
                    set_bus_err = 1'b1;
                    next_state  = S_TRAP;
                end
            end
            S_EXEC_R: begin
                a_sel_c    = 2'd2;
                alu_c      = alu_decode(funct3, funct7[5], 1'b1);
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                a_sel_c    = 2'd2;
                b_sel_c    = 2'd1;
                alu_c      = alu_decode(funct3, funct7[5], 1'b0);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                out_sel_c   = 3'd1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_JALR: begin
                a_sel_c    = 2'd2;
                b_sel_c    = 2'd1;
                next_state = S_JAL;
            end
            // Target already sits in ALUOut; the ALU now forms the link value.
            S_JAL: begin
                pc_write_c = 1'b1;
                out_sel_c  = 3'd1;
                a_sel_c    = 2'd1;
                b_sel_c    = 2'd2;
                next_state = S_ALUWB;
            end
            S_BRANCH: begin
                a_sel_c   = 2'd2;
                out_sel_c = 3'd1;
                case (funct3[2:1])
                    2'b10:   alu_c = ALU_SLT;
                    2'b11:   alu_c = ALU_SLTU;
                    default: alu_c = ALU_SUB;
                endcase
                case (funct3)
                    3'b000, 3'b101, 3'b111: pc_write_c = zero_flag;
                    3'b001, 3'b100, 3'b110: pc_write_c = ~zero_flag;
                    default:                pc_write_c = 1'b0;
                endcase
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_LUI: begin
                a_sel_c    = 2'd3;
                b_sel_c    = 2'd1;
                imm_sel_c  = IMM_U;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                a_sel_c    = 2'd1;
                b_sel_c    = 2'd1;
                imm_sel_c  = IMM_U;
                next_state = S_ALUWB;
            end
            S_HALT: begin
                halted_c = 1'b1;
                oe_c     = 1'b1;
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            illegal_q     <= 1'b0;
            bus_err_q     <= 1'b0;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (set_bus_err)
                bus_err_q <= 1'b1;
            if (retire)
                retired_count <= retired_count + 1'b1;
        end
    end

    // Reset must silence the bus immediately, even though the state register sits in FETCH.
    assign adr_src       = rst & adr_src_c;
    assign mem_req       = rst & mem_req_c;
    assign mem_write     = rst & mem_write_c;
    assign pc_write      = rst & pc_write_c;
    assign ir_write      = rst & ir_write_c;
    assign reg_write     = rst & reg_write_c;
    assign alu_src_a_sel = rst ? a_sel_c : 2'd0;
    assign alu_src_b_sel = rst ? b_sel_c : 2'd0;
    assign imm_sel       = rst ? imm_sel_c : 3'd0;
    assign alu_ctrl      = rst ? alu_c : 4'd0;
    assign out_mux_sel   = rst ? out_sel_c : 3'd0;
    assign output_en     = rst & oe_c;
    assign halted        = rst & halted_c;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Randomized bench for riscv_mc_controller; a per-instruction-class reference model
// predicts cycle counts, write pulses, memory beats, ALU op and retirement.
module tb_riscv_mc_controller;
    logic clk, rst, rst_to;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic zero_flag, mem_ready, mem_ready_to;

    logic adr_src, mem_req, mem_write, pc_write, ir_write, reg_write, output_en;
    logic halted, illegal_instr, bus_error;
    logic [1:0] alu_src_a_sel, alu_src_b_sel;
    logic [2:0] imm_sel, out_mux_sel;
    logic [3:0] alu_ctrl;
    logic [31:0] retired_count;

    logic t_adr_src, t_mem_req, t_mem_write, t_pc_write, t_ir_write, t_reg_write, t_output_en;
    logic t_halted, t_illegal_instr, t_bus_error;
    logic [1:0] t_a, t_b;
    logic [2:0] t_imm, t_out;
    logic [3:0] t_alu;
    logic [7:0] t_retired;

    int total = 0;
    int bad   = 0;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    int alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [7:0] take_when_zero    = 8'b1010_0001;
    logic [7:0] take_when_nonzero = 8'b0101_0010;

    riscv_mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .mem_ready(mem_ready), .adr_src(adr_src), .mem_req(mem_req),
        .mem_write(mem_write), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .imm_sel(imm_sel),
        .alu_ctrl(alu_ctrl), .out_mux_sel(out_mux_sel), .output_en(output_en), .halted(halted),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .retired_count(retired_count)
    );

    riscv_mc_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(8)) dut_to (
        .clk(clk), .rst(rst_to), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .mem_ready(mem_ready_to), .adr_src(t_adr_src), .mem_req(t_mem_req),
        .mem_write(t_mem_write), .pc_write(t_pc_write), .ir_write(t_ir_write),
        .reg_write(t_reg_write), .alu_src_a_sel(t_a), .alu_src_b_sel(t_b), .imm_sel(t_imm),
        .alu_ctrl(t_alu), .out_mux_sel(t_out), .output_en(t_output_en), .halted(t_halted),
        .illegal_instr(t_illegal_instr), .bus_error(t_bus_error), .retired_count(t_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH, with fw fetch waits and mw data waits, and checks it.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic zf, input int fw, input int mw, input string name);
        int cyc = 0, rw = 0, pcw = 0, dreq = 0, dwr = 0, acc = 0;
        int wbsel = -1, wb_alu = -1, prev_alu = -1, last_alu = -1;
        int e_cyc, e_rw, e_pcw, e_dreq, e_dwr, e_wbsel, e_alu;
        logic [31:0] start_rc;
        bit done = 0;
        bit taken;
        start_rc = retired_count;
        opcode = op; funct3 = f3; funct7 = f7; zero_flag = zf;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (acc == (adr_src ? mw : fw));
                acc = mem_ready ? 0 : acc + 1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            if (reg_write) begin
                rw++;
                wbsel  = int'(out_mux_sel);
                wb_alu = prev_alu;
            end
            prev_alu = int'(alu_ctrl);
            last_alu = int'(alu_ctrl);
            if (pc_write && !ir_write) pcw++;
            if (mem_req && adr_src) dreq++;
            if (mem_write) dwr++;
            @(posedge clk);
            #1;
            if (retired_count != start_rc || halted || illegal_instr || bus_error) done = 1;
        end
        taken = zf ? take_when_zero[f3] : take_when_nonzero[f3];
        e_rw = 1; e_pcw = 0; e_dreq = 0; e_dwr = 0; e_wbsel = 1; e_alu = -1;
        case (op)
            7'b0110011: begin
                e_cyc = 4;
                e_alu = alu_base[f3];
                if (f3 == 3'd5 && f7[5]) e_alu = 7;
                if (f3 == 3'd0 && f7[5]) e_alu = 1;
            end
            7'b0010011: begin
                e_cyc = 4;
                e_alu = alu_base[f3];
                if (f3 == 3'd5 && f7[5]) e_alu = 7;
            end
            7'b0000011: begin e_cyc = 5 + mw; e_dreq = mw + 1; e_wbsel = 2; end
            7'b0100011: begin e_cyc = 4 + mw; e_dreq = mw + 1; e_dwr = mw + 1; e_rw = 0; end
            7'b1100011: begin e_cyc = 3; e_rw = 0; e_pcw = taken ? 1 : 0; end
            7'b1101111: begin e_cyc = 4; e_pcw = 1; end
            7'b1100111: begin e_cyc = 5; e_pcw = 1; end
            default:    e_cyc = 4;
        endcase
        e_cyc += fw;
        total++; if (cyc !== e_cyc) begin bad++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, e_cyc); end
        total++; if (rw !== e_rw) begin bad++; $display("FAIL %s reg_write pulses: got %0d want %0d", name, rw, e_rw); end
        total++; if (pcw !== e_pcw) begin bad++; $display("FAIL %s pc_write pulses: got %0d want %0d", name, pcw, e_pcw); end
        total++; if (dreq !== e_dreq) begin bad++; $display("FAIL %s data req cycles: got %0d want %0d", name, dreq, e_dreq); end
        total++; if (dwr !== e_dwr) begin bad++; $display("FAIL %s mem_write cycles: got %0d want %0d", name, dwr, e_dwr); end
        total++; if (retired_count !== start_rc + 32'd1) begin bad++; $display("FAIL %s retired: got %0d want %0d", name, retired_count, start_rc + 1); end
        if (e_rw == 1) begin
            total++; if (wbsel !== e_wbsel) begin bad++; $display("FAIL %s wb select: got %0d want %0d", name, wbsel, e_wbsel); end
        end
        if (e_alu >= 0) begin
            total++; if (wb_alu !== e_alu) begin bad++; $display("FAIL %s alu_ctrl: got %0d want %0d", name, wb_alu, e_alu); end
        end
        if (op == 7'b1100011 && f3[2:1] != 2'b01) begin
            e_alu = (f3[2:1] == 2'b00) ? 1 : (f3[2:1] == 2'b10) ? 3 : 4;
            total++; if (last_alu !== e_alu) begin bad++; $display("FAIL %s branch alu_ctrl: got %0d want %0d", name, last_alu, e_alu); end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        total++;
        if ({adr_src, mem_req, mem_write, pc_write, ir_write, reg_write, alu_src_a_sel, alu_src_b_sel,
             imm_sel, alu_ctrl, out_mux_sel, output_en, halted, illegal_instr, bus_error} !== 26'd0) begin
            bad++; $display("FAIL reset outputs: got nonzero, want all zero");
        end
        total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL reset retired: got %0d want 0", retired_count); end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b1 || adr_src !== 1'b0) begin bad++; $display("FAIL reset release fetch: mem_req=%b adr_src=%b want 1 0", mem_req, adr_src); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_instr(7'b0110011, 3'd0, 7'd0, 1'b0, 0, 0, "r_add");
        run_instr(7'b0110011, 3'd0, 7'h20, 1'b0, 0, 0, "r_sub");
        run_instr(7'b0010011, 3'd0, 7'h20, 1'b0, 0, 0, "addi_no_sub");
        run_instr(7'b0010011, 3'd5, 7'h20, 1'b0, 1, 0, "srai");
        run_instr(7'b0000011, 3'd2, 7'd0, 1'b0, 0, 3, "load_wait3");
        run_instr(7'b0100011, 3'd2, 7'd0, 1'b0, 0, 2, "store_wait2");
        run_instr(7'b1100011, 3'd0, 7'd0, 1'b1, 0, 0, "beq_taken");
        run_instr(7'b1100011, 3'd0, 7'd0, 1'b0, 0, 0, "beq_not");
        run_instr(7'b1100011, 3'd6, 7'd0, 1'b0, 0, 0, "bltu_taken");
        run_instr(7'b1100011, 3'd2, 7'd0, 1'b1, 0, 0, "br_f3_010");
        run_instr(7'b1101111, 3'd0, 7'd0, 1'b0, 0, 0, "jal");
        run_instr(7'b1100111, 3'd0, 7'd0, 1'b0, 0, 0, "jalr");
        run_instr(7'b0110111, 3'd0, 7'd0, 1'b0, 0, 0, "lui");
        run_instr(7'b0010111, 3'd0, 7'd0, 1'b0, 12, 0, "auipc_long_wait");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_instr(legal_ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_terminal(input logic [6:0] op, input bit is_halt);
        logic [31:0] rc;
        int cyc = 0;
        rc = retired_count;
        opcode = op;
        while (!(halted || illegal_instr) && cyc < 20) begin
            @(negedge clk);
            mem_ready = mem_req;
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (cyc !== 2) begin bad++; $display("FAIL terminal %b entry cycles: got %0d want 2", op, cyc); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (halted !== is_halt || output_en !== is_halt || illegal_instr !== !is_halt ||
                mem_req !== 1'b0 || retired_count !== rc) begin
                bad++;
                $display("FAIL terminal %b hold: halted=%b oe=%b illegal=%b req=%b retired=%0d want %b %b %b 0 %0d",
                         op, halted, output_en, illegal_instr, mem_req, retired_count, is_halt, is_halt, !is_halt, rc);
            end
        end
        do_reset();
        total++; if (halted !== 1'b0 || illegal_instr !== 1'b0 || output_en !== 1'b0) begin bad++; $display("FAIL terminal %b clear: flags still set after reset", op); end
    endtask

    task automatic test_reset_mid_write();
        int cyc = 0;
        run_instr(7'b0110011, 3'd0, 7'd0, 1'b0, 0, 0, "pre_rst_add");
        opcode = 7'b0100011;
        @(negedge clk);
        while (!mem_write && cyc < 20) begin
            mem_ready = mem_req && !adr_src;
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
        #1;
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rst_mid reach: never reached store access"); end
        rst = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || mem_write !== 1'b0 || retired_count !== 32'd0) begin
            bad++; $display("FAIL rst_mid drop: req=%b wr=%b retired=%0d want 0 0 0", mem_req, mem_write, retired_count);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b1 || adr_src !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_mid release: req=%b adr=%b wr=%b want 1 0 0", mem_req, adr_src, mem_write); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        rst_to = 1'b0;
        mem_ready_to = 1'b0;
        @(negedge clk);
        rst_to = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mem_ready_to = (i == 4);
            #1;
            if (i == 4) begin
                total++; if (t_ir_write !== 1'b1) begin bad++; $display("FAIL timeout last_cycle ready: ir_write=%b want 1", t_ir_write); end
            end
            @(negedge clk);
        end
        mem_ready_to = 1'b0;
        #1;
        total++; if (t_bus_error !== 1'b0) begin bad++; $display("FAIL timeout late accept: bus_error=%b want 0", t_bus_error); end
        rst_to = 1'b0;
        @(negedge clk);
        rst_to = 1'b1;
        #1;
        while (!t_bus_error && n < 50) begin
            if (t_mem_req) n++;
            @(negedge clk);
            #1;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL timeout req cycles: got %0d want 4", n); end
        for (int i = 0; i < 20; i++) begin
            total++;
            if (t_bus_error !== 1'b1 || t_mem_req !== 1'b0 || t_illegal_instr !== 1'b0) begin
                bad++; $display("FAIL timeout hold: bus_error=%b req=%b illegal=%b want 1 0 0", t_bus_error, t_mem_req, t_illegal_instr);
            end
            mem_ready_to = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; rst_to = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        zero_flag = 1'b0; mem_ready = 1'b0; mem_ready_to = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_terminal(7'b0000000, 1'b0);
        test_terminal(7'b1110011, 1'b1);
        test_reset_mid_write();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
